// File: rtl/display_blink_controller.sv
// display_blink_controller: time-edit FSM that blinks the digit pair of the
// field being edited and registers the digit codes for the 7-seg decoders.
// Ports: clk, reset (sync, active-high), tick (blink-rate enable),
//   editEn (edit-mode level), nextField (advance pulse),
//   valueIn[23:0] (six BCD codes, [23:20]=hour tens),
//   isOn[5:0] (per-digit enable, bit5=hour tens),
//   bch[23:0] (registered digit codes), field[1:0] (current state).
// Optional macro LEADING_ZERO_BLANK_EN: blanks a zero hour-tens digit in IDLE.
module display_blink_controller #(
    parameter int BLINK_HALF = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        editEn,
    input  logic        nextField,
    input  logic [23:0] valueIn,
    output logic [5:0]  isOn,
    output logic [23:0] bch,
    output logic [1:0]  field
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EDIT_HOUR = 2'd1,
        EDIT_MIN  = 2'd2,
        EDIT_SEC  = 2'd3
    } state_t;

    localparam logic [7:0] LAST = 8'(BLINK_HALF - 1);

    state_t     state;
    state_t     state_n;
    logic [7:0] cnt;
    logic [7:0] cnt_n;
    logic       phase;
    logic       phase_n;
    logic [5:0] on_n;
    logic [23:0] bch_n;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (editEn) state_n = EDIT_HOUR;
            end
            EDIT_HOUR: begin
                if (!editEn) state_n = IDLE;
                else if (nextField) state_n = EDIT_MIN;
            end
            EDIT_MIN: begin
                if (!editEn) state_n = IDLE;
                else if (nextField) state_n = EDIT_SEC;
            end
            EDIT_SEC: begin
                if (!editEn) state_n = IDLE;
                else if (nextField) state_n = EDIT_HOUR;
            end
            default: state_n = IDLE;
        endcase
    end

    // A state change (or staying idle) restarts the blink visible,
    // winning over any tick on the same edge.
    always_comb begin
        cnt_n   = cnt;
        phase_n = phase;
        if (state_n != state || state_n == IDLE) begin
            cnt_n   = 8'd0;
            phase_n = 1'b1;
        end else if (tick) begin
            if (cnt == LAST) begin
                cnt_n   = 8'd0;
                phase_n = ~phase;
            end else begin
                cnt_n = cnt + 8'd1;
            end
        end
    end

    // Enables come from next-state values so isOn moves with field.
    always_comb begin
        on_n = 6'b111111;
        unique case (state_n)
            EDIT_HOUR: on_n[5:4] = {2{phase_n}};
            EDIT_MIN:  on_n[3:2] = {2{phase_n}};
            EDIT_SEC:  on_n[1:0] = {2{phase_n}};
            default:   on_n = 6'b111111;
        endcase
    end

    always_comb begin
        bch_n = valueIn;
`ifdef LEADING_ZERO_BLANK_EN
        if (state_n == IDLE && valueIn[23:20] == 4'd0)
            bch_n[23:20] = 4'd10;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 8'd0;
            phase <= 1'b1;
            isOn  <= 6'b111111;
            bch   <= 24'hAAAAAA;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            phase <= phase_n;
            isOn  <= on_n;
            bch   <= bch_n;
        end
    end

    assign field = state;

endmodule

// File: tb/tb_display_blink_controller.sv
// Scoreboard bench for display_blink_controller (BLINK_HALF=2).
// Stimulus pushes hand-computed expectations; a monitor pops and checks.
module tb_display_blink_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic        editEn;
    logic        nextField;
    logic [23:0] valueIn;
    logic [5:0]  isOn;
    logic [23:0] bch;
    logic [1:0]  field;

    typedef struct packed {
        logic [1:0]  f;
        logic [5:0]  on;
        logic [23:0] b;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    display_blink_controller #(.BLINK_HALF(2)) dut (
        .clk(clk), .reset(reset), .tick(tick), .editEn(editEn),
        .nextField(nextField), .valueIn(valueIn),
        .isOn(isOn), .bch(bch), .field(field)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] exp_bch(input logic [23:0] v,
                                            input logic [1:0] f);
        logic [23:0] r;
        r = v;
`ifdef LEADING_ZERO_BLANK_EN
        if (f == 2'd0 && v[23:20] == 4'd0) r[23:20] = 4'hA;
`endif
        return r;
    endfunction

    task automatic step(input logic r, input logic e, input logic n,
                        input logic t, input logic [23:0] v,
                        input logic [1:0] f, input logic [5:0] on);
        exp_t x;
        @(negedge clk);
        reset = r; editEn = e; nextField = n; tick = t; valueIn = v;
        x.f  = f;
        x.on = on;
        x.b  = r ? 24'hAAAAAA : exp_bch(v, f);
        q.push_back(x);
        @(posedge clk);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                checks++;
                if (field !== x.f) begin
                    errors++;
                    $display("FAIL field: got %0d want %0d", field, x.f);
                end
                checks++;
                if (isOn !== x.on) begin
                    errors++;
                    $display("FAIL isOn: got %h want %h", isOn, x.on);
                end
                checks++;
                if (bch !== x.b) begin
                    errors++;
                    $display("FAIL bch: got %h want %h", bch, x.b);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; tick = 1'b0; editEn = 1'b0;
        nextField = 1'b0; valueIn = 24'h0;
        // reset, then release
        step(1, 0, 0, 0, 24'h123456, 2'd0, 6'h3F);
        step(1, 0, 0, 0, 24'h123456, 2'd0, 6'h3F);
        step(0, 0, 0, 0, 24'h123456, 2'd0, 6'h3F);
        // nextField ignored in IDLE
        step(0, 0, 1, 1, 24'h123456, 2'd0, 6'h3F);
        // enter edit, tick every cycle: 3F,3F,0F,0F,3F,3F,0F
        step(0, 1, 0, 1, 24'h123456, 2'd1, 6'h3F);
        step(0, 1, 0, 1, 24'h123456, 2'd1, 6'h3F);
        step(0, 1, 0, 1, 24'h123456, 2'd1, 6'h0F);
        step(0, 1, 0, 1, 24'h123456, 2'd1, 6'h0F);
        step(0, 1, 0, 1, 24'h123456, 2'd1, 6'h3F);
        step(0, 1, 0, 1, 24'h123456, 2'd1, 6'h3F);
        step(0, 1, 0, 1, 24'h123456, 2'd1, 6'h0F);
        // editEn drop overrides nextField while hidden
        step(0, 0, 1, 1, 24'h123456, 2'd0, 6'h3F);
        // re-enter, advance to MIN, blink to hidden
        step(0, 1, 0, 0, 24'h123456, 2'd1, 6'h3F);
        step(0, 1, 1, 0, 24'h123456, 2'd2, 6'h3F);
        step(0, 1, 0, 1, 24'h123456, 2'd2, 6'h3F);
        step(0, 1, 0, 1, 24'h123456, 2'd2, 6'h33);
        // nextField + tick while hidden: SEC, visible restart
        step(0, 1, 1, 1, 24'h123456, 2'd3, 6'h3F);
        step(0, 1, 0, 1, 24'h123456, 2'd3, 6'h3F);
        step(0, 1, 0, 1, 24'h123456, 2'd3, 6'h3C);
        // no tick: hold
        step(0, 1, 0, 0, 24'h123456, 2'd3, 6'h3C);
        step(0, 1, 0, 0, 24'h123456, 2'd3, 6'h3C);
        // SEC wraps to HOUR, visible
        step(0, 1, 1, 0, 24'h123456, 2'd1, 6'h3F);
        step(0, 1, 0, 1, 24'h123456, 2'd1, 6'h3F);
        step(0, 1, 0, 0, 24'h012345, 2'd1, 6'h3F);
        step(0, 1, 0, 1, 24'h012345, 2'd1, 6'h0F);
        // reset mid-blink wins over everything
        step(1, 1, 1, 1, 24'h012345, 2'd0, 6'h3F);
        step(0, 0, 0, 0, 24'h012345, 2'd0, 6'h3F);
        step(0, 1, 0, 0, 24'h012345, 2'd1, 6'h3F);
        step(0, 0, 0, 1, 24'h012345, 2'd0, 6'h3F);
        // codes 10..15 pass through
        step(0, 0, 0, 0, 24'hFEDCBA, 2'd0, 6'h3F);
        step(0, 0, 0, 1, 24'h0A0F00, 2'd0, 6'h3F);
        step(0, 0, 0, 0, 24'h0A0F00, 2'd0, 6'h3F);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_blink_controller.md
DISPLAY_BLINK_CONTROLLER -- requirements
Module: display_blink_controller

Interface
REQ-001 Parameter BLINK_HALF, default 2, number of tick pulses per blink half-period (legal 1..255).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 tick  input  1  single-cycle blink-rate enable pulse.
REQ-005 editEn  input  1  level; high = time-edit mode requested.
REQ-006 nextField  input  1  single-cycle pulse; advance edited field.
REQ-007 valueIn  input  24  six 4-bit digit codes, [23:20]=hour tens .. [3:0]=second units.
REQ-008 isOn  output  6  per-digit enable to the 7-segment decoders, bit5=hour tens.
REQ-009 bch  output  24  registered digit codes to decoders, same packing as valueIn.
REQ-010 field  output  2  current state: 0 IDLE, 1 EDIT_HOUR, 2 EDIT_MIN, 3 EDIT_SEC.

Function
REQ-011 FSM states IDLE, EDIT_HOUR, EDIT_MIN, EDIT_SEC; field SHALL equal the state encoding, registered.
REQ-012 IDLE with editEn=1 SHALL go to EDIT_HOUR next cycle.
REQ-013 Any EDIT state with editEn=0 SHALL go to IDLE next cycle, overriding nextField.
REQ-014 With editEn=1, nextField SHALL advance HOUR->MIN->SEC->HOUR (wrap); nextField in IDLE ignored.
REQ-015 Blink counter (8 bit) SHALL increment on tick; at BLINK_HALF-1 with tick it SHALL clear and toggle phase.
REQ-016 Any state change SHALL clear counter to 0 and set phase=1 (visible) in the same edge, taking priority over a simultaneous tick.
REQ-017 In IDLE, phase SHALL be held at 1 and counter at 0.
REQ-018 isOn SHALL be 6'b111111 except the two digits of the current EDIT field, which SHALL equal phase (hour=bits5:4, min=3:2, sec=1:0).
REQ-019 isOn SHALL be registered, derived from next-state values, so it reflects a state change in the same cycle as field.
REQ-020 bch SHALL equal valueIn delayed by exactly one cycle; codes pass unmodified (including 10..15) except per REQ-026.
REQ-021 No other digit, state or counter change SHALL occur on cycles without tick, nextField or an editEn transition.

Reset
REQ-022 reset SHALL force state IDLE, field=0, counter=0, phase=1 on the next edge.
REQ-023 reset SHALL force isOn=6'b111111 and bch=24'hAAAAAA (all digits blank code 10).
REQ-024 reset SHALL take priority over all other inputs, including mid-edit and mid-blink.
REQ-025 First cycle after reset release SHALL behave per Function with no residual blink phase.

Configuration
REQ-026 Macro LEADING_ZERO_BLANK_EN defined: in IDLE, if valueIn[23:20]==0 then bch[23:20] SHALL be 4'd10 (blank); in EDIT states hour tens passes unmodified so the edited field shows 0.
REQ-027 Macro LEADING_ZERO_BLANK_EN undefined: bch SHALL always be valueIn delayed one cycle, no substitution.

Verification
REQ-028 reset=1 two cycles, valueIn=24'h123456 -> isOn=6'h3F, field=0, bch=24'hAAAAAA; release -> next cycle bch=24'h123456.
REQ-029 editEn=1, BLINK_HALF=2, tick every cycle -> field=1; isOn alternates 6'h3F,6'h3F,6'h0F,6'h0F,... (2-tick half-periods).
REQ-030 In EDIT_SEC, nextField pulse -> field=1, isOn=6'h3F same cycle as field change, counter restarted.
REQ-031 nextField and tick same cycle while phase=0 in EDIT_MIN -> field=3, isOn=6'h3F, blink restarts from visible.
REQ-032 editEn 1->0 with nextField=1 in EDIT_HOUR, phase=0 -> field=0, isOn=6'h3F next cycle.
REQ-033 LEADING_ZERO_BLANK_EN defined, valueIn=24'h012345 IDLE -> bch=24'hA12345; editEn=1 -> bch=24'h012345 once field=1.
